mp64_tile_arb: RTL and testbench

Round-robin arbiter that shares the single 512-bit tile memory port between NREQ requesters: tile engine, DMA, and CPU line access. It sits between the requesters' tile_req/tile_ack interfaces and the tile BRAM. Only one transaction is outstanding at a time. Request fields are latched at grant, and the downstream request is a single-cycle pulse, matching the 1-cycle-latency tile BRAM.

---
 rtl/mp64_tile_arb.sv | 149 ++++++++++++++
 tb/tb_mp64_tile_arb.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp64_tile_arb.sv
// mp64_tile_arb: round-robin arbiter sharing the single 512-bit tile memory
// port between NREQ requesters (index 0 = tile engine). One transaction is
// outstanding at a time. Request fields are latched at grant, and mem_req is
// a one-cycle pulse sized for the 1-cycle-latency tile BRAM.
// Optional build macro: TILE_ARB_STATS_EN adds per-requester grant counters
// and a conflict counter, read through stat_sel/stat_data.
module mp64_tile_arb #(
  parameter int NREQ = 3,
  parameter int AW   = 20,
  parameter int DW   = 512
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ-1:0]    req_wen,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [DW-1:0]      req_rdata,
  output logic [NREQ-1:0]    req_ack,
  output logic               mem_req,
  output logic [AW-1:0]      mem_addr,
  output logic               mem_wen,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata,
  input  logic               mem_ack,
  output logic               arb_busy,
  output logic [1:0]         arb_grant
`ifdef TILE_ARB_STATS_EN
  ,
  input  logic               stat_clr,
  input  logic [1:0]         stat_sel,
  output logic [31:0]        stat_data
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t     state;
  logic [1:0] rr_ptr;
  logic [1:0] win_idx;
  logic       win_vld;
  logic [1:0] rr_next;

  // Pick the first requesting index, searching circularly from rr_ptr.
  always_comb begin
    logic [2:0] cand;
    cand    = '0;
    win_idx = 2'd0;
    win_vld = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + 3'(k);
      if (cand >= 3'(NREQ)) cand = cand - 3'(NREQ);
      if (!win_vld && req_req[cand[1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[1:0];
      end
    end
  end

  // After a completion the requester just served drops to lowest priority.
  assign rr_next = (arb_grant == 2'(NREQ - 1)) ? 2'd0 : arb_grant + 2'd1;

  // Arbitration FSM: IDLE grants and latches, ISSUE pulses mem_req, WAIT
  // holds until the memory acknowledges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= 2'd0;
      arb_grant <= 2'd0;
      mem_req   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      arb_busy  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            state     <= S_ISSUE;
            mem_req   <= 1'b1;
            arb_busy  <= 1'b1;
            arb_grant <= win_idx;
            mem_addr  <= req_addr[int'(win_idx)*AW +: AW];
            mem_wen   <= req_wen[win_idx];
            mem_wdata <= req_wdata[int'(win_idx)*DW +: DW];
          end
        end
        S_ISSUE: begin
          mem_req <= 1'b0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_ack) begin
            state    <= S_IDLE;
            arb_busy <= 1'b0;
            rr_ptr   <= rr_next;
          end
        end
        default: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  // Completion is forwarded only while waiting; stray acks in IDLE/ISSUE
  // (e.g. a late ack after reset) are dropped.
  always_comb begin
    req_ack = '0;
    if (state == S_WAIT && mem_ack) req_ack[arb_grant] = 1'b1;
  end

  assign req_rdata = mem_rdata;

`ifdef TILE_ARB_STATS_EN
  logic [31:0] grant_cnt [NREQ];
  logic [31:0] conf_cnt;
  logic        grant_fire;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign grant_fire = (state == S_IDLE) && win_vld;

  // Saturating grant and conflict counters, cleared by reset or stat_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) grant_cnt[i] <= '0;
      conf_cnt <= '0;
    end else if (stat_clr) begin
      for (int i = 0; i < NREQ; i++) grant_cnt[i] <= '0;
      conf_cnt <= '0;
    end else if (grant_fire) begin
      grant_cnt[win_idx] <= sat_inc(grant_cnt[win_idx]);
      if ($countones(req_req) >= 2) conf_cnt <= sat_inc(conf_cnt);
    end
  end

  // Counter readback mux.
  always_comb begin
    stat_data = '0;
    if (stat_sel == 2'd3) stat_data = conf_cnt;
    else if (int'(stat_sel) < NREQ) stat_data = grant_cnt[stat_sel];
  end
`endif

endmodule

// File: tb/tb_mp64_tile_arb.sv
// Testbench for mp64_tile_arb: directed scenarios plus randomized traffic
// against a transaction-level round-robin model with a 1-cycle BRAM.
module tb_mp64_tile_arb;
  localparam int NREQ = 3;
  localparam int AW   = 20;
  localparam int DW   = 512;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    req_wen;
  logic [NREQ*DW-1:0] req_wdata;
  logic [DW-1:0]      req_rdata;
  logic [NREQ-1:0]    req_ack;
  logic               mem_req;
  logic [AW-1:0]      mem_addr;
  logic               mem_wen;
  logic [DW-1:0]      mem_wdata;
  logic [DW-1:0]      mem_rdata = '0;
  logic               mem_ack = 1'b0;
  logic               arb_busy;
  logic [1:0]         arb_grant;
`ifdef TILE_ARB_STATS_EN
  logic               stat_clr;
  logic [1:0]         stat_sel;
  logic [31:0]        stat_data;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  mp64_tile_arb #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_req(req_req), .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata),
    .req_rdata(req_rdata), .req_ack(req_ack),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .arb_busy(arb_busy), .arb_grant(arb_grant)
`ifdef TILE_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_sel(stat_sel), .stat_data(stat_data)
`endif
  );

  // ---------------- BRAM model ----------------
  logic [DW-1:0] bram    [64];
  logic [DW-1:0] ref_mem [64];
  int            bram_lat = 1;
  logic          do_init  = 1'b0;
  int            pend_cnt = 0;
  logic [AW-1:0] pend_addr = '0;
  logic          pend_wen  = 1'b0;
  logic [DW-1:0] pend_wdata = '0;

  function automatic logic [DW-1:0] tile_init(input int i);
    logic [7:0] b;
    b = (i == 3) ? 8'hFF : 8'(i + 1);
    return {64{b}};
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int k = 0; k < DW/32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  always @(posedge clk) begin
    mem_ack <= 1'b0;
    if (do_init) begin
      for (int i = 0; i < 64; i++) bram[i] <= tile_init(i);
    end else if (pend_cnt > 0) begin
      if (pend_cnt == 1) begin
        mem_ack   <= 1'b1;
        mem_rdata <= bram[pend_addr[11:6]];
        if (pend_wen) bram[pend_addr[11:6]] <= pend_wdata;
      end
      pend_cnt <= pend_cnt - 1;
    end else if (mem_req) begin
      if (bram_lat <= 1) begin
        mem_ack   <= 1'b1;
        mem_rdata <= bram[mem_addr[11:6]];
        if (mem_wen) bram[mem_addr[11:6]] <= mem_wdata;
      end else begin
        pend_addr  <= mem_addr;
        pend_wen   <= mem_wen;
        pend_wdata <= mem_wdata;
        pend_cnt   <= bram_lat - 1;
      end
    end
  end

  // ---------------- helpers (stimulus only) ----------------
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    req_req[i]            = 1'b1;
    req_addr[i*AW +: AW]  = a;
    req_wen[i]            = w;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_req = '0; req_wen = '0; req_addr = '0; req_wdata = '0;
    bram_lat = 1;
`ifdef TILE_ARB_STATS_EN
    stat_clr = 1'b0; stat_sel = 2'd0;
`endif
    do_init = 1'b1;
    step();
    do_init = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = tile_init(i);
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_ack(output logic [NREQ-1:0] ack, output int n);
    ack = '0;
    n = 0;
    while (n < 20 && ack == '0) begin
      step();
      n++;
      ack = req_ack;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    req_req = '1; req_wen = '1; req_addr = '1; req_wdata = '1;
`ifdef TILE_ARB_STATS_EN
    stat_clr = 1'b0; stat_sel = 2'd0;
`endif
    step(); step(); step();
    n_tests++; if (mem_req !== 1'b0)  begin n_fail++; $display("FAIL reset_mem_req got=%0b want=0", mem_req); end
    n_tests++; if (arb_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b want=0", arb_busy); end
    n_tests++; if (arb_grant !== 2'd0) begin n_fail++; $display("FAIL reset_grant got=%0d want=0", arb_grant); end
    n_tests++; if (mem_addr !== '0 || mem_wen !== 1'b0 || mem_wdata !== '0)
      begin n_fail++; $display("FAIL reset_mem_fields addr=%h wen=%0b", mem_addr, mem_wen); end
    n_tests++; if (req_ack !== '0) begin n_fail++; $display("FAIL reset_ack got=%b want=000", req_ack); end
  endtask

  task automatic test_single_read();
    apply_reset();
    set_req(0, 20'h00040, 1'b0, '0);
    step();
    n_tests++; if (mem_req !== 1'b1 || arb_busy !== 1'b1 || arb_grant !== 2'd0)
      begin n_fail++; $display("FAIL single_issue mem_req=%0b busy=%0b grant=%0d want 1/1/0", mem_req, arb_busy, arb_grant); end
    n_tests++; if (mem_addr !== 20'h00040 || req_ack !== '0)
      begin n_fail++; $display("FAIL single_latch addr=%h ack=%b want 00040/000", mem_addr, req_ack); end
    step();
    n_tests++; if (req_ack !== 3'b001 || mem_req !== 1'b0)
      begin n_fail++; $display("FAIL single_ack ack=%b mem_req=%0b want 001/0", req_ack, mem_req); end
    n_tests++; if (req_rdata !== {64{8'h02}}) begin n_fail++; $display("FAIL single_rdata got=%h want 02-fill", req_rdata[31:0]); end
    req_req = '0;
    step();
    n_tests++; if (arb_busy !== 1'b0 || req_ack !== '0)
      begin n_fail++; $display("FAIL single_done busy=%0b ack=%b want 0/000", arb_busy, req_ack); end
  endtask

  task automatic test_contention();
    logic [NREQ-1:0] ack;
    int n;
    int tiles[3] = '{0, 1, 3};
    apply_reset();
    set_req(0, 20'h00000, 1'b0, '0);
    set_req(1, 20'h00040, 1'b0, '0);
    set_req(2, 20'h000C0, 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      wait_ack(ack, n);
      n_tests++; if (ack !== 3'(1 << k)) begin n_fail++; $display("FAIL contend_order%0d got=%b want=%b", k, ack, 3'(1 << k)); end
      n_tests++; if (req_rdata !== tile_init(tiles[k])) begin n_fail++; $display("FAIL contend_rdata%0d got=%h", k, req_rdata[31:0]); end
      n_tests++; if (n !== ((k == 0) ? 2 : 3)) begin n_fail++; $display("FAIL contend_gap%0d got=%0d want=%0d", k, n, (k == 0) ? 2 : 3); end
      req_req[k] = 1'b0;
    end
    step();
  endtask

  task automatic test_write_read();
    logic [NREQ-1:0] ack;
    int n;
    apply_reset();
    set_req(1, 20'h00080, 1'b1, {64{8'hA5}});
    wait_ack(ack, n);
    n_tests++; if (ack !== 3'b010) begin n_fail++; $display("FAIL wr_ack got=%b want=010", ack); end
    req_req = '0;
    set_req(2, 20'h00080, 1'b0, '0);
    wait_ack(ack, n);
    n_tests++; if (ack !== 3'b100) begin n_fail++; $display("FAIL rd_ack got=%b want=100", ack); end
    n_tests++; if (req_rdata !== {64{8'hA5}}) begin n_fail++; $display("FAIL rd_data got=%h want A5-fill", req_rdata[31:0]); end
    req_req = '0;
    step();
    n_tests++; if (req_ack !== '0) begin n_fail++; $display("FAIL wr_rd_quiet ack=%b want=000", req_ack); end
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] ack;
    int n;
    int exp_seq[4] = '{0, 2, 0, 2};
    apply_reset();
    set_req(0, 20'h00000, 1'b0, '0);
    set_req(2, 20'h000C0, 1'b0, '0);
    for (int k = 0; k < 4; k++) begin
      wait_ack(ack, n);
      n_tests++; if (ack !== 3'(1 << exp_seq[k])) begin n_fail++; $display("FAIL fair_seq%0d got=%b want=%b", k, ack, 3'(1 << exp_seq[k])); end
      if (exp_seq[k] == 0) req_addr[0 +: AW] = AW'(64 * (k + 1));
    end
    req_req = '0;
    step(); step(); step(); step();
  endtask

  task automatic test_latch();
    logic [NREQ-1:0] ack;
    int n;
    logic [DW-1:0] d;
    apply_reset();
    d = rand_data();
    set_req(0, 20'h000C0, 1'b1, d);
    step();
    set_req(0, 20'h003C0, 1'b0, ~d);
    n_tests++; if (mem_addr !== 20'h000C0 || mem_wen !== 1'b1 || mem_wdata !== d)
      begin n_fail++; $display("FAIL latch_issue addr=%h wen=%0b want 000C0/1", mem_addr, mem_wen); end
    step();
    n_tests++; if (req_ack !== 3'b001 || mem_addr !== 20'h000C0)
      begin n_fail++; $display("FAIL latch_wait ack=%b addr=%h want 001/000C0", req_ack, mem_addr); end
    req_req = '0;
    step();
    set_req(1, 20'h000C0, 1'b0, '0);
    wait_ack(ack, n);
    n_tests++; if (ack !== 3'b010 || req_rdata !== d)
      begin n_fail++; $display("FAIL latch_readback ack=%b data=%h want 010/%h", ack, req_rdata[31:0], d[31:0]); end
    req_req = '0;
    step();
  endtask

  task automatic test_reset_midflight();
    logic [NREQ-1:0] ack;
    int n;
    apply_reset();
    set_req(1, 20'h00000, 1'b0, '0);
    wait_ack(ack, n);
    n_tests++; if (ack !== 3'b010) begin n_fail++; $display("FAIL mid_pre_ack got=%b want=010", ack); end
    req_req = '0;
    bram_lat = 3;
    set_req(2, 20'h00040, 1'b0, '0);
    step(); step();
    n_tests++; if (arb_busy !== 1'b1 || arb_grant !== 2'd2)
      begin n_fail++; $display("FAIL mid_wait busy=%0b grant=%0d want 1/2", arb_busy, arb_grant); end
    rst_n = 1'b0;
    req_req = '0;
    #1;
    n_tests++; if (mem_req !== 1'b0 || arb_busy !== 1'b0 || arb_grant !== 2'd0)
      begin n_fail++; $display("FAIL mid_rst mem_req=%0b busy=%0b grant=%0d want 0/0/0", mem_req, arb_busy, arb_grant); end
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      n_tests++; if (req_ack !== '0 || mem_req !== 1'b0 || arb_busy !== 1'b0)
        begin n_fail++; $display("FAIL mid_late_ack%0d ack=%b mem_req=%0b busy=%0b want 000/0/0", k, req_ack, mem_req, arb_busy); end
    end
    bram_lat = 1;
    set_req(1, 20'h00000, 1'b0, '0);
    set_req(2, 20'h00040, 1'b0, '0);
    wait_ack(ack, n);
    n_tests++; if (ack !== 3'b010 || arb_grant !== 2'd1 || req_rdata !== {64{8'h01}})
      begin n_fail++; $display("FAIL mid_resume ack=%b grant=%0d want 010/1", ack, arb_grant); end
    req_req[1] = 1'b0;
    wait_ack(ack, n);
    n_tests++; if (ack !== 3'b100) begin n_fail++; $display("FAIL mid_resume2 ack=%b want=100", ack); end
    req_req = '0;
    step();
  endtask

  task automatic new_txn(input int i);
    set_req(i, AW'($urandom_range(0, 1023)), ($urandom_range(0, 2) == 0), rand_data());
  endtask

  task automatic test_random();
    logic [NREQ-1:0] exp_ack;
    logic [AW-1:0]   e_addr;
    logic            e_wen;
    logic [DW-1:0]   e_wdata;
    int free_c, grant_c, ack_c, last, win, max_wait;
    int wait_c[NREQ];
    apply_reset();
    free_c = cyc; grant_c = -1; ack_c = -1; last = NREQ - 1; win = 0; max_wait = 0;
    e_addr = '0; e_wen = 1'b0; e_wdata = '0;
    for (int i = 0; i < NREQ; i++) wait_c[i] = 0;
    for (int it = 0; it < 600; it++) begin
      if (cyc == free_c) begin
        if (req_req != '0) begin
          win     = rr_pick(req_req, last);
          last    = win;
          grant_c = cyc;
          ack_c   = cyc + 2;
          free_c  = cyc + 3;
          e_addr  = req_addr[win*AW +: AW];
          e_wen   = req_wen[win];
          e_wdata = req_wdata[win*DW +: DW];
        end else begin
          free_c = cyc + 1;
        end
      end
      step();
      exp_ack = '0;
      if (cyc == ack_c) exp_ack[win] = 1'b1;
      n_tests++; if (req_ack !== exp_ack) begin n_fail++; $display("FAIL rnd_ack c=%0d got=%b want=%b", cyc, req_ack, exp_ack); end
      n_tests++; if (mem_req !== (cyc == ack_c - 1)) begin n_fail++; $display("FAIL rnd_mem_req c=%0d got=%0b", cyc, mem_req); end
      n_tests++; if (arb_busy !== (cyc > grant_c && cyc <= ack_c)) begin n_fail++; $display("FAIL rnd_busy c=%0d got=%0b", cyc, arb_busy); end
      if (cyc == ack_c) begin
        n_tests++; if (mem_addr !== e_addr || mem_wen !== e_wen || mem_wdata !== e_wdata)
          begin n_fail++; $display("FAIL rnd_fields c=%0d addr=%h want=%h wen=%0b want=%0b", cyc, mem_addr, e_addr, mem_wen, e_wen); end
        if (!e_wen) begin
          n_tests++; if (req_rdata !== ref_mem[e_addr[11:6]])
            begin n_fail++; $display("FAIL rnd_rdata c=%0d got=%h want=%h", cyc, req_rdata[31:0], ref_mem[e_addr[11:6]][31:0]); end
        end else begin
          ref_mem[e_addr[11:6]] = e_wdata;
        end
        wait_c[win] = 0;
        if ($urandom_range(0, 1) == 0) new_txn(win);
        else req_req[win] = 1'b0;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_req[i]) begin
          wait_c[i]++;
          if (wait_c[i] > max_wait) max_wait = wait_c[i];
        end else if ($urandom_range(0, 2) == 0) begin
          new_txn(i);
        end
      end
    end
    n_tests++; if (max_wait > 3 * NREQ + 3) begin n_fail++; $display("FAIL rnd_fair_wait got=%0d want<=%0d", max_wait, 3 * NREQ + 3); end
    req_req = '0;
    step(); step(); step(); step();
  endtask

`ifdef TILE_ARB_STATS_EN
  task automatic test_stats();
    logic [NREQ-1:0] ack;
    int n;
    int exp_v[4] = '{2, 2, 2, 4};
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      set_req(0, 20'h00000, 1'b0, '0);
      set_req(1, 20'h00040, 1'b0, '0);
      set_req(2, 20'h000C0, 1'b0, '0);
      for (int k = 0; k < 3; k++) begin
        wait_ack(ack, n);
        req_req = req_req & ~ack;
      end
      step();
    end
    for (int s = 0; s < 4; s++) begin
      stat_sel = 2'(s);
      #1;
      n_tests++; if (stat_data !== 32'(exp_v[s])) begin n_fail++; $display("FAIL stat_sel%0d got=%0d want=%0d", s, stat_data, exp_v[s]); end
    end
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    for (int s = 0; s < 4; s++) begin
      stat_sel = 2'(s);
      #1;
      n_tests++; if (stat_data !== 32'd0) begin n_fail++; $display("FAIL stat_clr_sel%0d got=%0d want=0", s, stat_data); end
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write_read();
    test_fairness();
    test_latch();
    test_reset_midflight();
    test_random();
`ifdef TILE_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
